// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the seven-segment scan decoder.
// Segment patterns are active-low {g,f,e,d,c,b,a}. Blank-digit decoding is
// controlled by the SSEG_BLANK_EN macro inside sseg_digit_lut.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal weights for the reassembly; sum of four digits fits in 14 bits
  localparam logic [13:0] W_THOU   = 14'd1000;
  localparam logic [13:0] W_HUND   = 14'd100;
  localparam logic [13:0] W_TEN    = 14'd10;
  localparam logic [13:0] W_ONE    = 14'd1;
  localparam logic [13:0] DATA_MAX = 14'd8191;

  typedef enum logic [1:0] {
    SYNC,
    CAPT,
    CONVERT
  } state_t;

  // One scan-line sample: anode select plus segment pattern (dp dropped)
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

endpackage

// File: rtl/sseg_digit_lut.sv
// sseg_digit_lut: 7-bit active-low segment pattern -> {legal, bcd}.
// SSEG_BLANK_EN: when defined, the all-off pattern decodes as digit 0 so
// leading-blank displays reassemble correctly; otherwise it is illegal.
module sseg_digit_lut
  import sseg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       legal,
  output logic [3:0] bcd
);

  // Pattern lookup; anything not in the table is flagged illegal
  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (pat)
      SEG_0: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
`ifdef SSEG_BLANK_EN
      SEG_BLANK: bcd = 4'd0;
`else
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_decoder.sv
// sseg_decoder: samples multiplexed sseg/an scan lines, qualifies each digit
// for stability, decodes four digits and reassembles the binary value.
// Optional blank-digit decoding via SSEG_BLANK_EN (see sseg_digit_lut).
module sseg_decoder
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  sseg,
  input  logic [3:0]  an,
  output logic [12:0] data,
  output logic        valid,
  output logic        err
);

  localparam int         IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 2);

  sample_t                        pin_smp, smp;
  logic [3:0]                     s_an;
  logic [6:0]                     s_sseg;
  logic [7:0]                     cnt;
  logic                           match, accept;
  logic                           an_blank, an_onehot, an_bad;
  logic [IDX_W-1:0]               an_idx;
  logic                           pat_legal;
  logic [3:0]                     pat_bcd;
  logic                           cap, cap_legal, cap_illegal, cap_an_err;
  logic [NUM_DIGITS-1:0]          mask, mask_nxt;
  logic [NUM_DIGITS-1:0][3:0]     digit;
  logic [13:0]                    sum;
  logic                           valid_nxt, err_nxt;
  state_t                         state, state_nxt;
  logic                           unused_dp;

  assign unused_dp = sseg[7];
  assign pin_smp   = '{an: an, seg: sseg[6:0]};
  assign s_an      = smp.an;
  assign s_sseg    = smp.seg;

  // The sample entering the register is compared with the one already held,
  // so the Nth identical sample is recognised on the edge that registers it.
  assign match  = (pin_smp == smp);
  assign accept = match && (cnt == CNT_ACC);

  // Input register and saturating stability counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp <= '{an: 4'hF, seg: SEG_BLANK};
      cnt <= '0;
    end else begin
      smp <= pin_smp;
      if (!match)              cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
    end
  end

  // Anode classification and digit index of the active-low select
  assign an_blank  = &s_an;
  assign an_onehot = $onehot(~s_an);
  assign an_bad    = !an_blank && !an_onehot;

  // Index of the low anode bit (meaningful only when one-hot-low)
  always_comb begin
    an_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!s_an[i]) an_idx = IDX_W'(i);
  end

  sseg_digit_lut u_lut (
    .pat   (s_sseg),
    .legal (pat_legal),
    .bcd   (pat_bcd)
  );

  // Acceptances are acted on in SYNC as well as CAPT so a digit accepted in
  // the cycle after CONVERT is not lost.
  assign cap         = accept && (state != CONVERT);
  assign cap_an_err  = cap && an_bad;
  assign cap_legal   = cap && an_onehot && pat_legal;
  assign cap_illegal = cap && an_onehot && !pat_legal;

  // Mask update: SYNC clears first, then this cycle's capture is applied
  always_comb begin
    mask_nxt = (state == SYNC) ? '0 : mask;
    if (cap_an_err)       mask_nxt = '0;
    else if (cap_legal)   mask_nxt[an_idx] = 1'b1;
    else if (cap_illegal) mask_nxt[an_idx] = 1'b0;
  end

  // Decimal reassembly of the stored digits
  always_comb begin
    sum = {10'd0, digit[3]} * W_THOU + {10'd0, digit[2]} * W_HUND
        + {10'd0, digit[1]} * W_TEN  + {10'd0, digit[0]} * W_ONE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    state_nxt = CAPT;
      CAPT: begin
        if (cap_an_err)            state_nxt = SYNC;
        else if (mask_nxt == '1)   state_nxt = CONVERT;
      end
      CONVERT: state_nxt = SYNC;
      default: state_nxt = SYNC;
    endcase
  end

  // FSM outputs: pulse requests registered below
  always_comb begin
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      CONVERT: begin
        if (sum <= DATA_MAX) valid_nxt = 1'b1;
        else                 err_nxt   = 1'b1;
      end
      default: err_nxt = cap_an_err || cap_illegal;
    endcase
  end

  // Capture mask, digit storage and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask  <= '0;
      digit <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      mask  <= mask_nxt;
      if (cap_legal) digit[an_idx] <= pat_bcd;
      if (valid_nxt) data <= sum[12:0];
      valid <= valid_nxt;
      err   <= err_nxt;
    end
  end

endmodule
